// File: rtl/pilha_pkg.sv
// Shared constants for the Pilha stack controller: op-codes, FSM encoding
// and default geometry.
package pilha_pkg;

    localparam int LARGURA_PADRAO = 16;
    localparam int TAMANHO_PADRAO = 64;
    localparam int END_W_PADRAO   = 6;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_PEEK = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ESCREVE  = 2'b01,
        LE       = 2'b10,
        RESPOSTA = 2'b11
    } estado_t;

endpackage

// File: rtl/controlador_pilha_contador_ponteiro.sv
// Up/down stack-pointer counter; the pointer value is the occupancy itself,
// with full/empty flags derived from it.
module contador_ponteiro
#(
    parameter int TAMANHO = 64,
    parameter int END_W   = 6
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [END_W:0]   ocupacao,
    output logic             cheia,
    output logic             vazia
);

    localparam logic [END_W:0] UM    = (END_W+1)'(1);
    localparam logic [END_W:0] CHEIO = (END_W+1)'(TAMANHO);

    logic [END_W:0] sp;

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (inc && !dec) begin
            sp <= sp + UM;
        end else if (dec && !inc) begin
            sp <= sp - UM;
        end
    end

    assign ocupacao = sp;
    assign cheia    = (sp == CHEIO);
    assign vazia    = (sp == '0);

endmodule

// File: rtl/controlador_pilha.sv
// Sequencer for the 16x64 Pilha stack bank: PUSH/POP/PEEK over valid/ready.
// Optional macro PILHA_ERRO_STICKY_EN makes erro sticky until a NOP or reset.
module controlador_pilha
    import pilha_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO,
    parameter int TAMANHO = TAMANHO_PADRAO,
    parameter int END_W   = END_W_PADRAO
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_op,
    input  logic [LARGURA-1:0] cmd_dado,
    output logic               cmd_ready,
    output logic               resp_valid,
    output logic [LARGURA-1:0] resp_dado,
    output logic               erro,
    output logic               cheia,
    output logic               vazia,
    output logic [END_W:0]     ocupacao,
    output logic [END_W-1:0]   mem_endereco,
    output logic               mem_io,
    output logic [LARGURA-1:0] mem_dado_w,
    input  logic [LARGURA-1:0] mem_dado_r
);

    estado_t estado, prox_estado;

    logic aceita;
    logic inc, dec;
    logic carrega_w, carrega_r, captura;
    logic falha;

    contador_ponteiro #(
        .TAMANHO (TAMANHO),
        .END_W   (END_W)
    ) u_ponteiro (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc),
        .dec      (dec),
        .ocupacao (ocupacao),
        .cheia    (cheia),
        .vazia    (vazia)
    );

    assign cmd_ready  = (estado == IDLE);
    assign aceita     = cmd_valid && cmd_ready;
    assign mem_io     = (estado == ESCREVE);
    assign resp_valid = (estado == RESPOSTA);

    always_comb begin
        prox_estado = estado;
        inc         = 1'b0;
        dec         = 1'b0;
        carrega_w   = 1'b0;
        carrega_r   = 1'b0;
        captura     = 1'b0;
        falha       = 1'b0;
        case (estado)
            IDLE: begin
                if (aceita) begin
                    case (cmd_op)
                        OP_PUSH: begin
                            if (cheia) begin
                                falha = 1'b1;
                            end else begin
                                inc         = 1'b1;
                                carrega_w   = 1'b1;
                                prox_estado = ESCREVE;
                            end
                        end
                        OP_POP, OP_PEEK: begin
                            if (vazia) begin
                                falha = 1'b1;
                            end else begin
                                dec         = (cmd_op == OP_POP);
                                carrega_r   = 1'b1;
                                prox_estado = LE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ESCREVE:  prox_estado = IDLE;
            LE: begin
                captura     = 1'b1;
                prox_estado = RESPOSTA;
            end
            RESPOSTA: prox_estado = IDLE;
            default:  prox_estado = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= IDLE;
        end else begin
            estado <= prox_estado;
        end
    end

    // Memory port and response registers; POP/PEEK both address the top word.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_endereco <= '0;
            mem_dado_w   <= '0;
            resp_dado    <= '0;
        end else begin
            if (carrega_w) begin
                mem_endereco <= ocupacao[END_W-1:0];
                mem_dado_w   <= cmd_dado;
            end else if (carrega_r) begin
                mem_endereco <= ocupacao[END_W-1:0] - END_W'(1);
            end
            if (captura) begin
                resp_dado <= mem_dado_r;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            erro <= 1'b0;
        end else begin
`ifdef PILHA_ERRO_STICKY_EN
            if (aceita && cmd_op == OP_NOP) begin
                erro <= 1'b0;
            end else if (falha) begin
                erro <= 1'b1;
            end
`else
            erro <= falha;
`endif
        end
    end

endmodule

// File: tb/tb_controlador_pilha.sv
// Self-checking bench for controlador_pilha with a behavioural Pilha model
// and a response scoreboard.
module tb_controlador_pilha;
    import pilha_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_dado;
    logic        cmd_ready;
    logic        resp_valid;
    logic [15:0] resp_dado;
    logic        erro;
    logic        cheia;
    logic        vazia;
    logic [6:0]  ocupacao;
    logic [5:0]  mem_endereco;
    logic        mem_io;
    logic [15:0] mem_dado_w;
    logic [15:0] mem_dado_r;

    logic [15:0] pilha [64];
    logic [15:0] esperado [$];

    int total = 0;
    int bad   = 0;

    controlador_pilha dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_dado     (cmd_dado),
        .cmd_ready    (cmd_ready),
        .resp_valid   (resp_valid),
        .resp_dado    (resp_dado),
        .erro         (erro),
        .cheia        (cheia),
        .vazia        (vazia),
        .ocupacao     (ocupacao),
        .mem_endereco (mem_endereco),
        .mem_io       (mem_io),
        .mem_dado_w   (mem_dado_w),
        .mem_dado_r   (mem_dado_r)
    );

    always #5 clk = ~clk;

    assign mem_dado_r = pilha[mem_endereco];

    always @(posedge clk) begin
        if (mem_io) pilha[mem_endereco] <= mem_dado_w;
    end

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    // Scoreboard: every response strobe must match the oldest queued value.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (esperado.size() == 0) begin
                verifica("resp_unexpected", 32'd1, 32'd0);
            end else begin
                verifica("resp_dado", {16'd0, resp_dado}, {16'd0, esperado.pop_front()});
            end
        end
    end

    task automatic reinicia();
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Returns just after the acceptance edge T, i.e. inside cycle T+1.
    task automatic envia(input logic [1:0] op, input logic [15:0] dado);
        int espera;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dado  = dado;
        espera    = 0;
        while (cmd_ready !== 1'b1 && espera < 20) begin
            @(negedge clk);
            espera++;
        end
        if (espera >= 20) verifica("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_op = OP_NOP;
    endtask

    task automatic le_chk(input logic [1:0] op, input logic [15:0] esp);
        esperado.push_back(esp);
        envia(op, 16'h0);
        @(negedge clk);
        verifica("resp_t1", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        verifica("resp_t2", {31'd0, resp_valid}, 32'd1);
        @(negedge clk);
        verifica("resp_t3", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_dado = '0;
        for (int i = 0; i < 64; i++) pilha[i] = 16'hDEAD;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        verifica("rst_ready", {31'd0, cmd_ready}, 32'd1);
        verifica("rst_vazia", {31'd0, vazia}, 32'd1);
        verifica("rst_cheia", {31'd0, cheia}, 32'd0);
        verifica("rst_ocup", {25'd0, ocupacao}, 32'd0);
        verifica("rst_io", {31'd0, mem_io}, 32'd0);
        verifica("rst_resp", {31'd0, resp_valid}, 32'd0);
        verifica("rst_erro", {31'd0, erro}, 32'd0);

        // Single PUSH
        envia(OP_PUSH, 16'h1234);
        @(negedge clk);
        verifica("push_io", {31'd0, mem_io}, 32'd1);
        verifica("push_end", {26'd0, mem_endereco}, 32'd0);
        verifica("push_dado", {16'd0, mem_dado_w}, 32'h1234);
        verifica("push_ready0", {31'd0, cmd_ready}, 32'd0);
        verifica("push_ocup", {25'd0, ocupacao}, 32'd1);
        verifica("push_vazia", {31'd0, vazia}, 32'd0);
        @(negedge clk);
        verifica("push_io_end", {31'd0, mem_io}, 32'd0);
        verifica("push_ready1", {31'd0, cmd_ready}, 32'd1);

        // LIFO order
        reinicia();
        envia(OP_PUSH, 16'h0001);
        envia(OP_PUSH, 16'h0002);
        envia(OP_PUSH, 16'h0003);
        le_chk(OP_POP, 16'h0003);
        le_chk(OP_POP, 16'h0002);
        le_chk(OP_POP, 16'h0001);
        verifica("lifo_vazia", {31'd0, vazia}, 32'd1);

        // PEEK leaves the pointer alone
        reinicia();
        envia(OP_PUSH, 16'hBEEF);
        le_chk(OP_PEEK, 16'hBEEF);
        le_chk(OP_PEEK, 16'hBEEF);
        verifica("peek_ocup", {25'd0, ocupacao}, 32'd1);
        le_chk(OP_POP, 16'hBEEF);
        verifica("peek_pop_ocup", {25'd0, ocupacao}, 32'd0);

        // Fill to capacity, then overflow
        reinicia();
        for (int i = 0; i < 64; i++) envia(OP_PUSH, 16'(i));
        @(negedge clk);
        @(negedge clk);
        verifica("full_cheia", {31'd0, cheia}, 32'd1);
        verifica("full_ocup", {25'd0, ocupacao}, 32'd64);
        envia(OP_PUSH, 16'hFFFF);
        @(negedge clk);
        verifica("ovf_erro", {31'd0, erro}, 32'd1);
        verifica("ovf_io", {31'd0, mem_io}, 32'd0);
        verifica("ovf_ready", {31'd0, cmd_ready}, 32'd1);
        verifica("ovf_ocup", {25'd0, ocupacao}, 32'd64);
        le_chk(OP_POP, 16'd63);
        verifica("ovf_pop_ocup", {25'd0, ocupacao}, 32'd63);

        // Underflow and erro lifetime
        reinicia();
        envia(OP_POP, 16'h0);
        @(negedge clk);
        verifica("unf_erro", {31'd0, erro}, 32'd1);
        verifica("unf_resp", {31'd0, resp_valid}, 32'd0);
        verifica("unf_ocup", {25'd0, ocupacao}, 32'd0);
        @(negedge clk);
`ifdef PILHA_ERRO_STICKY_EN
        verifica("unf_sticky", {31'd0, erro}, 32'd1);
        envia(OP_NOP, 16'h0);
        @(negedge clk);
        verifica("nop_clear", {31'd0, erro}, 32'd0);
`else
        verifica("unf_pulse", {31'd0, erro}, 32'd0);
        envia(OP_NOP, 16'h0);
        @(negedge clk);
        verifica("nop_noeffect", {31'd0, erro}, 32'd0);
`endif

        // Reset during the LE cycle of a POP
        reinicia();
        envia(OP_PUSH, 16'h0055);
        envia(OP_PUSH, 16'h0066);
        envia(OP_POP, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        verifica("abort_ready", {31'd0, cmd_ready}, 32'd1);
        verifica("abort_resp", {31'd0, resp_valid}, 32'd0);
        verifica("abort_ocup", {25'd0, ocupacao}, 32'd0);
        verifica("abort_io", {31'd0, mem_io}, 32'd0);
        repeat (3) @(negedge clk);

        verifica("queue_drained", esperado.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
